// File: rtl/gp_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : gp_apb_master
// Purpose  : Single-outstanding APB master. It accepts one command over a
//            valid/ready handshake, runs an APB SETUP/ACCESS transfer and
//            returns the result over a valid/ready response handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   cmd_valid_i/ready_o    command handshake (ready only while idle)
//   cmd_write_i            1 = write, 0 = read
//   cmd_addr_i/wdata_i     command address / write data
//   rsp_valid_o/ready_i    response handshake
//   rsp_rdata_o            read data (0 for writes and timeouts)
//   rsp_slverr_o           slave error or timeout
//   rsp_timeout_o          transfer aborted by the ACCESS timeout
//   paddr_o, pwdata_o, pwrite_o, psel_o, penable_o   APB request
//   prdata_i, pready_i, pslverr_i                    APB completion
// Configuration:
//   GP_APB_MASTER_TIMEOUT_EN  when defined, an ACCESS phase that sees no
//                             pready_i for TIMEOUT_CYCLES cycles is aborted
//                             with slverr and timeout set. Otherwise ACCESS
//                             waits indefinitely and rsp_timeout_o is 0.
// ============================================================================
module gp_apb_master #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic                      cmd_write_i,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_slverr_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic w_accept;
  logic w_complete;
  logic w_timeout;

  logic [APB_ADDR_WIDTH-1:0] r_paddr;
  logic [APB_DATA_WIDTH-1:0] r_pwdata;
  logic                      r_pwrite;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_slverr;

  assign w_accept   = cmd_valid_i & (r_state == IDLE);
  assign w_complete = (r_state == ACCESS) & pready_i;

`ifdef GP_APB_MASTER_TIMEOUT_EN
  localparam logic [15:0] c_timeout_last = 16'(TIMEOUT_CYCLES - 1);

  // Counts completed ACCESS cycles without pready_i; zeroed while in SETUP so
  // it reads 0 on the first ACCESS cycle.
  logic [15:0] r_access_cnt;
  logic        r_rsp_timeout;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_access_cnt <= 16'd0;
    end else if (r_state == SETUP) begin
      r_access_cnt <= 16'd0;
    end else if ((r_state == ACCESS) && !pready_i) begin
      r_access_cnt <= r_access_cnt + 16'd1;
    end
  end

  // A late pready_i on the final allowed cycle still completes normally.
  assign w_timeout = (r_state == ACCESS) & ~pready_i & (r_access_cnt == c_timeout_last);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_complete) begin
      r_rsp_timeout <= 1'b0;
    end else if (w_timeout) begin
      r_rsp_timeout <= 1'b1;
    end
  end

  assign rsp_timeout_o = r_rsp_timeout;
`else
  assign w_timeout     = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ACCESS;
      ACCESS:  if (w_complete || w_timeout) w_state_nxt = RESP;
      RESP:    if (rsp_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields load only on accept, so they are stable for the whole
  // transfer and keep their last value afterwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_pwrite <= 1'b0;
    end else if (w_accept) begin
      r_paddr  <= cmd_addr_i;
      r_pwdata <= cmd_wdata_i;
      r_pwrite <= cmd_write_i;
    end
  end

  // Response fields load only at completion or timeout; prdata_i/pslverr_i
  // are ignored in every other cycle.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b0;
    end else if (w_complete) begin
      r_rsp_rdata  <= r_pwrite ? '0 : prdata_i;
      r_rsp_slverr <= pslverr_i;
    end else if (w_timeout) begin
      r_rsp_rdata  <= '0;
      r_rsp_slverr <= 1'b1;
    end
  end

  // Control outputs decode straight from the state register so the async
  // reset removes psel_o/penable_o/rsp_valid_o immediately. cmd_ready_o is
  // additionally gated by rst_n_i so it reads 0 while reset is held.
  assign cmd_ready_o  = rst_n_i & (r_state == IDLE);
  assign psel_o       = (r_state == SETUP) | (r_state == ACCESS);
  assign penable_o    = (r_state == ACCESS);
  assign rsp_valid_o  = (r_state == RESP);
  assign paddr_o      = r_paddr;
  assign pwdata_o     = r_pwdata;
  assign pwrite_o     = r_pwrite;
  assign rsp_rdata_o  = r_rsp_rdata;
  assign rsp_slverr_o = r_rsp_slverr;

endmodule
`default_nettype wire

// File: tb/tb_gp_apb_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_gp_apb_master
// Purpose  : Directed self-checking bench for gp_apb_master. Inputs are
//            driven and outputs sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gp_apb_master;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk_i;
  logic          rst_n_i;
  logic          cmd_valid_i;
  logic          cmd_ready_o;
  logic          cmd_write_i;
  logic [AW-1:0] cmd_addr_i;
  logic [DW-1:0] cmd_wdata_i;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_slverr_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] paddr_o;
  logic [DW-1:0] pwdata_o;
  logic          pwrite_o;
  logic          psel_o;
  logic          penable_o;
  logic [DW-1:0] prdata_i;
  logic          pready_i;
  logic          pslverr_i;

  int n_vec;
  int n_err;

  gp_apb_master #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_write_i  (cmd_write_i),
    .cmd_addr_i   (cmd_addr_i),
    .cmd_wdata_i  (cmd_wdata_i),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_ready_i  (rsp_ready_i),
    .rsp_rdata_o  (rsp_rdata_o),
    .rsp_slverr_o (rsp_slverr_o),
    .rsp_timeout_o(rsp_timeout_o),
    .paddr_o      (paddr_o),
    .pwdata_o     (pwdata_o),
    .pwrite_o     (pwrite_o),
    .psel_o       (psel_o),
    .penable_o    (penable_o),
    .prdata_i     (prdata_i),
    .pready_i     (pready_i),
    .pslverr_i    (pslverr_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Drive one command through the accept edge; returns at the SETUP-cycle
  // falling edge with cmd_valid_i dropped.
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL issue_ready: cmd_ready_o=%b required 1", cmd_ready_o);
    end
    cmd_valid_i = 1'b1;
    cmd_write_i = wr;
    cmd_addr_i  = a;
    cmd_wdata_i = d;
    @(negedge clk_i);
    cmd_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    n_vec++;
    if ({psel_o, penable_o, rsp_valid_o, rsp_slverr_o, rsp_timeout_o, pwrite_o} !== 6'b0 ||
        paddr_o !== '0 || pwdata_o !== '0 || rsp_rdata_o !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: psel=%b pen=%b rvalid=%b paddr=%h pwdata=%h rdata=%h required all 0",
               psel_o, penable_o, rsp_valid_o, paddr_o, pwdata_o, rsp_rdata_o);
    end
    rst_n_i = 1'b1;
    @(negedge clk_i);
    n_vec++;
    if (cmd_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: cmd_ready_o=%b required 1", cmd_ready_o);
    end
  endtask

  task automatic test_write_zero_wait();
    pready_i    = 1'b1;
    pslverr_i   = 1'b0;
    rsp_ready_i = 1'b1;
    prdata_i    = 32'h1234_5678;
    issue(1'b1, 32'h08, 32'hDEAD_BEEF);
    n_vec++;
    if ({psel_o, penable_o, pwrite_o, cmd_ready_o} !== 4'b1010 ||
        paddr_o !== 32'h08 || pwdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL wr_setup: psel=%b pen=%b pwrite=%b rdy=%b paddr=%h pwdata=%h required 1 0 1 0 08 deadbeef",
               psel_o, penable_o, pwrite_o, cmd_ready_o, paddr_o, pwdata_o);
    end
    @(negedge clk_i);
    n_vec++;
    if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin
      n_err++;
      $display("FAIL wr_access: psel=%b pen=%b rvalid=%b required 1 1 0", psel_o, penable_o, rsp_valid_o);
    end
    @(negedge clk_i);
    n_vec++;
    if ({rsp_valid_o, rsp_slverr_o, rsp_timeout_o, psel_o, penable_o} !== 5'b10000 ||
        rsp_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL wr_resp: rvalid=%b slverr=%b tmo=%b psel=%b pen=%b rdata=%h required 1 0 0 0 0 0",
               rsp_valid_o, rsp_slverr_o, rsp_timeout_o, psel_o, penable_o, rsp_rdata_o);
    end
    @(negedge clk_i);
    n_vec++;
    if ({rsp_valid_o, cmd_ready_o} !== 2'b01) begin
      n_err++;
      $display("FAIL wr_idle: rvalid=%b rdy=%b required 0 1", rsp_valid_o, cmd_ready_o);
    end
  endtask

  task automatic test_read_waits();
    pready_i    = 1'b0;
    pslverr_i   = 1'b1;            // ignored while pready_i is low
    rsp_ready_i = 1'b1;
    prdata_i    = 32'hBAD0_BAD0;   // ignored while pready_i is low
    issue(1'b0, 32'h08, 32'h0);
    n_vec++;
    if ({psel_o, penable_o, pwrite_o} !== 3'b100 || paddr_o !== 32'h08) begin
      n_err++;
      $display("FAIL rd_setup: psel=%b pen=%b pwrite=%b paddr=%h required 1 0 0 08",
               psel_o, penable_o, pwrite_o, paddr_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({psel_o, penable_o, rsp_valid_o} !== 3'b110 || paddr_o !== 32'h08) begin
        n_err++;
        $display("FAIL rd_access%0d: psel=%b pen=%b rvalid=%b paddr=%h required 1 1 0 08",
                 i, psel_o, penable_o, rsp_valid_o, paddr_o);
      end
      if (i == 3) begin
        pready_i  = 1'b1;
        pslverr_i = 1'b0;
        prdata_i  = 32'hDEAD_BEEF;
      end
    end
    @(negedge clk_i);
    pready_i = 1'b0;
    prdata_i = 32'h5555_AAAA;
    n_vec++;
    if ({rsp_valid_o, rsp_slverr_o, psel_o} !== 3'b100 || rsp_rdata_o !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL rd_resp: rvalid=%b slverr=%b psel=%b rdata=%h required 1 0 0 deadbeef",
               rsp_valid_o, rsp_slverr_o, psel_o, rsp_rdata_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_slverr();
    pready_i    = 1'b1;
    pslverr_i   = 1'b1;
    rsp_ready_i = 1'b1;
    prdata_i    = 32'h0000_00E1;
    issue(1'b0, 32'h40, 32'h0);
    n_vec++;
    if (paddr_o !== 32'h40) begin
      n_err++;
      $display("FAIL err_addr: paddr=%h required 40", paddr_o);
    end
    repeat (2) @(negedge clk_i);
    pslverr_i = 1'b0;
    n_vec++;
    if ({rsp_valid_o, rsp_slverr_o, rsp_timeout_o} !== 3'b110 || rsp_rdata_o !== 32'hE1) begin
      n_err++;
      $display("FAIL err_resp: rvalid=%b slverr=%b tmo=%b rdata=%h required 1 1 0 e1",
               rsp_valid_o, rsp_slverr_o, rsp_timeout_o, rsp_rdata_o);
    end
    @(negedge clk_i);
  endtask

  task automatic test_backpressure();
    pready_i    = 1'b1;
    pslverr_i   = 1'b0;
    rsp_ready_i = 1'b0;
    prdata_i    = 32'hFFFF_0000;
    @(negedge clk_i);
    cmd_valid_i = 1'b1;
    cmd_write_i = 1'b1;
    cmd_addr_i  = 32'h10;
    cmd_wdata_i = 32'h0000_A5A5;
    @(negedge clk_i);                 // SETUP: offer the next command early
    cmd_write_i = 1'b0;
    cmd_addr_i  = 32'h20;
    cmd_wdata_i = 32'h0;
    @(negedge clk_i);                 // ACCESS
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({rsp_valid_o, rsp_slverr_o, cmd_ready_o, psel_o, penable_o} !== 5'b10000 ||
          rsp_rdata_o !== 32'h0 || paddr_o !== 32'h10 || pwrite_o !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold%0d: rvalid=%b slverr=%b rdy=%b psel=%b rdata=%h paddr=%h required 1 0 0 0 0 10",
                 i, rsp_valid_o, rsp_slverr_o, cmd_ready_o, psel_o, rsp_rdata_o, paddr_o);
      end
      if (i == 4) rsp_ready_i = 1'b1;
    end
    @(negedge clk_i);                 // IDLE after the handshake
    n_vec++;
    if ({rsp_valid_o, cmd_ready_o, psel_o} !== 3'b010) begin
      n_err++;
      $display("FAIL bp_idle: rvalid=%b rdy=%b psel=%b required 0 1 0", rsp_valid_o, cmd_ready_o, psel_o);
    end
    @(negedge clk_i);                 // second command now in SETUP
    cmd_valid_i = 1'b0;
    prdata_i    = 32'h0BAD_F00D;
    n_vec++;
    if ({psel_o, penable_o, pwrite_o} !== 3'b100 || paddr_o !== 32'h20) begin
      n_err++;
      $display("FAIL bp_next: psel=%b pen=%b pwrite=%b paddr=%h required 1 0 0 20",
               psel_o, penable_o, pwrite_o, paddr_o);
    end
    repeat (2) @(negedge clk_i);
    n_vec++;
    if (rsp_valid_o !== 1'b1 || rsp_rdata_o !== 32'h0BAD_F00D) begin
      n_err++;
      $display("FAIL bp_next_resp: rvalid=%b rdata=%h required 1 0badf00d", rsp_valid_o, rsp_rdata_o);
    end
    @(negedge clk_i);
  endtask

`ifdef GP_APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    pready_i    = 1'b0;
    rsp_ready_i = 1'b1;
    prdata_i    = 32'h7777_7777;
    issue(1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin
        n_err++;
        $display("FAIL tmo_access%0d: psel=%b pen=%b rvalid=%b required 1 1 0", i, psel_o, penable_o, rsp_valid_o);
      end
    end
    @(negedge clk_i);
    n_vec++;
    if ({rsp_valid_o, rsp_slverr_o, rsp_timeout_o, psel_o, penable_o} !== 5'b11100 ||
        rsp_rdata_o !== 32'h0) begin
      n_err++;
      $display("FAIL tmo_resp: rvalid=%b slverr=%b tmo=%b psel=%b rdata=%h required 1 1 1 0 0",
               rsp_valid_o, rsp_slverr_o, rsp_timeout_o, psel_o, rsp_rdata_o);
    end
    @(negedge clk_i);
  endtask
`else
  task automatic test_timeout();
    pready_i    = 1'b0;
    rsp_ready_i = 1'b1;
    prdata_i    = 32'h7777_7777;
    issue(1'b0, 32'h30, 32'h0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({psel_o, penable_o, rsp_valid_o} !== 3'b110) begin
        n_err++;
        $display("FAIL nto_wait%0d: psel=%b pen=%b rvalid=%b required 1 1 0", i, psel_o, penable_o, rsp_valid_o);
      end
    end
    pready_i = 1'b1;
    @(negedge clk_i);
    pready_i = 1'b0;
    n_vec++;
    if ({rsp_valid_o, rsp_slverr_o, rsp_timeout_o} !== 3'b100 || rsp_rdata_o !== 32'h7777_7777) begin
      n_err++;
      $display("FAIL nto_resp: rvalid=%b slverr=%b tmo=%b rdata=%h required 1 0 0 77777777",
               rsp_valid_o, rsp_slverr_o, rsp_timeout_o, rsp_rdata_o);
    end
    @(negedge clk_i);
  endtask
`endif

  task automatic test_reset_mid_access();
    pready_i    = 1'b0;
    rsp_ready_i = 1'b1;
    issue(1'b0, 32'h44, 32'h0);
    @(negedge clk_i);
    n_vec++;
    if ({psel_o, penable_o} !== 2'b11) begin
      n_err++;
      $display("FAIL rst_pre: psel=%b pen=%b required 1 1", psel_o, penable_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    n_vec++;
    if ({psel_o, penable_o, rsp_valid_o, cmd_ready_o} !== 4'b0000) begin
      n_err++;
      $display("FAIL rst_async: psel=%b pen=%b rvalid=%b rdy=%b required 0 0 0 0",
               psel_o, penable_o, rsp_valid_o, cmd_ready_o);
    end
    pready_i = 1'b1;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({rsp_valid_o, psel_o, cmd_ready_o} !== 3'b001) begin
        n_err++;
        $display("FAIL rst_after%0d: rvalid=%b psel=%b rdy=%b required 0 0 1",
                 i, rsp_valid_o, psel_o, cmd_ready_o);
      end
    end
    pready_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    rst_n_i     = 1'b0;
    cmd_valid_i = 1'b0;
    cmd_write_i = 1'b0;
    cmd_addr_i  = '0;
    cmd_wdata_i = '0;
    rsp_ready_i = 1'b0;
    prdata_i    = '0;
    pready_i    = 1'b0;
    pslverr_i   = 1'b0;

    test_reset();
    test_write_zero_wait();
    test_read_waits();
    test_slverr();
    test_backpressure();
    test_timeout();
    test_reset_mid_access();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
